// File: rtl/add32_sequencer.sv
// Sequences one 2*HALF_W-bit add/subtract through a shared HALF_W-bit adder:
// the low half goes first, then the high half with the carry chained in.
module add32_sequencer #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2*HALF_W-1:0]   op_a,
  input  logic [2*HALF_W-1:0]   op_b,
  input  logic                  op_sub,
  input  logic                  op_sign,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*HALF_W-1:0]   result,
  output logic                  ofl,
  output logic                  zero,
  output logic [HALF_W-1:0]     add_a,
  output logic [HALF_W-1:0]     add_b,
  output logic                  add_cin,
  output logic                  add_sign,
  input  logic [HALF_W-1:0]     add_sum,
  input  logic                  add_ofl
);

  localparam int W = 2 * HALF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           cin_q, cin_d;
  logic           sub_q, sub_d;
  logic           sign_q, sign_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   result_q, result_d;
  logic           ofl_q, ofl_d;
  logic           zero_q, zero_d;
  logic           resp_valid_q, resp_valid_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      cin_q        <= 1'b0;
      sub_q        <= 1'b0;
      sign_q       <= 1'b0;
      carry_q      <= 1'b0;
      result_q     <= {W{1'b0}};
      ofl_q        <= 1'b0;
      zero_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      sub_q        <= sub_d;
      sign_q       <= sign_d;
      carry_q      <= carry_d;
      result_q     <= result_d;
      ofl_q        <= ofl_d;
      zero_q       <= zero_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next-state logic and adder drive; the adder is only driven in LO/HI.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    sub_d        = sub_q;
    sign_d       = sign_q;
    carry_d      = carry_q;
    result_d     = result_q;
    ofl_d        = ofl_q;
    zero_d       = zero_q;
    resp_valid_d = resp_valid_q;
    add_a        = {HALF_W{1'b0}};
    add_b        = {HALF_W{1'b0}};
    add_cin      = 1'b0;
    add_sign     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          cin_d   = op_sub;
          sub_d   = op_sub;
          sign_d  = op_sign;
          state_d = LO;
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        add_a    = a_q[HALF_W-1:0];
        add_b    = b_q[HALF_W-1:0];
        add_cin  = cin_q;
        add_sign = 1'b0;
        result_d = {result_q[W-1:HALF_W], add_sum};
        carry_d  = add_ofl;
        state_d  = HI;
      end
      HI: begin
        add_a        = a_q[W-1:HALF_W];
        add_b        = b_q[W-1:HALF_W];
        add_cin      = carry_q;
        add_sign     = sign_q;
        result_d     = {add_sum, result_q[HALF_W-1:0]};
        // Unsigned subtract reports borrow, which is the inverted carry-out.
        ofl_d        = (sign_q || !sub_q) ? add_ofl : ~add_ofl;
        zero_d       = (add_sum == {HALF_W{1'b0}}) &&
                       (result_q[HALF_W-1:0] == {HALF_W{1'b0}});
        resp_valid_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d      = DONE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign result     = result_q;
  assign ofl        = ofl_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_add32_sequencer.sv
// Directed testbench for add32_sequencer with a behavioural model of the
// shared 16-bit adder closing the loop on add_* ports.
module tb_add32_sequencer;

  localparam int HALF_W = 16;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        op_sign;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        ofl;
  logic        zero;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic        add_sign;
  logic [15:0] add_sum;
  logic        add_ofl;
  logic [16:0] m_full;

  int n_checks;
  int n_fail;

  add32_sequencer #(.HALF_W(HALF_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_sub     (op_sub),
    .op_sign    (op_sign),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .ofl        (ofl),
    .zero       (zero),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sign   (add_sign),
    .add_sum    (add_sum),
    .add_ofl    (add_ofl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: carry-out when unsigned, signed overflow when signed.
  always_comb begin
    m_full  = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    add_sum = m_full[15:0];
    add_ofl = add_sign ? ((add_a[15] == add_b[15]) && (m_full[15] != add_a[15]))
                       : m_full[16];
  end

  // One full operation with resp_ready high; exp_hcin is the carry into the high pass.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sgn, input logic [31:0] exp_res,
                        input logic exp_ofl, input logic exp_zero, input logic exp_hcin);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; op_sign = sgn;
    req_valid = 1'b1; resp_ready = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL %s req_ready_idle: got %b want 1", nm, req_ready); n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D;
    n_checks++;
    if (req_ready !== 1'b0 || add_a !== a[15:0] || add_cin !== sub || add_sign !== 1'b0) begin
      $display("FAIL %s lo_drive: rdy=%b a=%h cin=%b sgn=%b want rdy=0 a=%h cin=%b sgn=0",
               nm, req_ready, add_a, add_cin, add_sign, a[15:0], sub);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || add_a !== a[31:16] ||
        add_cin !== exp_hcin || add_sign !== sgn) begin
      $display("FAIL %s hi_drive: rdy=%b rv=%b a=%h cin=%b sgn=%b want rdy=0 rv=0 a=%h cin=%b sgn=%b",
               nm, req_ready, resp_valid, add_a, add_cin, add_sign, a[31:16], exp_hcin, sgn);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0 || result !== exp_res ||
        ofl !== exp_ofl || zero !== exp_zero) begin
      $display("FAIL %s done: rv=%b rdy=%b res=%h ofl=%b z=%b want rv=1 rdy=0 res=%h ofl=%b z=%b",
               nm, resp_valid, req_ready, result, ofl, zero, exp_res, exp_ofl, exp_zero);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || add_a !== 16'h0000) begin
      $display("FAIL %s back_idle: rv=%b rdy=%b add_a=%h want rv=0 rdy=1 add_a=0000",
               nm, resp_valid, req_ready, add_a);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    op_a = 32'd0; op_b = 32'd0; op_sub = 1'b0; op_sign = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== 32'd0 || ofl !== 1'b0 || zero !== 1'b0 || resp_valid !== 1'b0 ||
        req_ready !== 1'b1 || add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0) begin
      $display("FAIL reset_state: res=%h ofl=%b z=%b rv=%b rdy=%b add_a=%h add_b=%h cin=%b",
               result, ofl, zero, resp_valid, req_ready, add_a, add_b, add_cin);
      n_fail++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_unsigned();
    run_op("add_ffff_1", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           32'h0001_0000, 1'b0, 1'b0, 1'b1);
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
           32'h0000_0000, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_sub_signed();
    run_op("ssub_min", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
           32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("ssub_5_3", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1,
           32'h0000_0002, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_sub_unsigned();
    run_op("usub_3_5", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0,
           32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    run_op("usub_5_3", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0,
           32'h0000_0002, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op_a = 32'h0000_0010; op_b = 32'h0000_0020; op_sub = 1'b0; op_sign = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op_a = 32'h0000_1234; op_b = 32'h0000_0001;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || result !== 32'h0000_0030 ||
          ofl !== 1'b0 || zero !== 1'b0) begin
        $display("FAIL bp_hold[%0d]: rv=%b rdy=%b res=%h ofl=%b z=%b want rv=1 rdy=0 res=00000030 ofl=0 z=0",
                 i, resp_valid, req_ready, result, ofl, zero);
        n_fail++;
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL bp_release: rv=%b rdy=%b want rv=0 rdy=1", resp_valid, req_ready);
      n_fail++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || add_a !== 16'h1234 || add_b !== 16'h0001) begin
      $display("FAIL bp_second_lo: rdy=%b add_a=%h add_b=%h want rdy=0 add_a=1234 add_b=0001",
               req_ready, add_a, add_b);
      n_fail++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b1 || result !== 32'h0000_1235 || ofl !== 1'b0) begin
      $display("FAIL bp_second_done: rv=%b res=%h ofl=%b want rv=1 res=00001235 ofl=0",
               resp_valid, result, ofl);
      n_fail++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; op_sub = 1'b0; op_sign = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (result !== 32'd0 || ofl !== 1'b0 || zero !== 1'b0 || resp_valid !== 1'b0 ||
        req_ready !== 1'b1 || add_a !== 16'd0) begin
      $display("FAIL rst_mid: res=%h ofl=%b z=%b rv=%b rdy=%b add_a=%h want all 0, rdy=1",
               result, ofl, zero, resp_valid, req_ready, add_a);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        $display("FAIL rst_no_resp[%0d]: rv=%b rdy=%b want rv=0 rdy=1", i, resp_valid, req_ready);
        n_fail++;
      end
    end
    run_op("after_rst", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0,
           32'h0000_0002, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add_unsigned();
    test_sub_signed();
    test_sub_unsigned();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add32_sequencer.md
Name: add32_sequencer

Overview:
- Multi-cycle controller that runs one 2*HALF_W-bit (default 32-bit) add/subtract through the existing shared HALF_W-bit CLA adder/subtractor.
- Uses two adder passes: low half first, then high half with the carry chained.
- Sits between a requester (e.g. a 32-bit ALU extension or a multiply/divide unit) and the adder. Drives the adder's InA/InB/Cin/sign inputs and samples its Out/Ofl outputs.
- Valid/ready handshake on both request and response sides.

Parameters:
- HALF_W, 16: width of the shared adder. Operand and result width is 2*HALF_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- op_a  in  2*HALF_W  operand A.
- op_b  in  2*HALF_W  operand B.
- op_sub  in  1  1 = A-B, 0 = A+B.
- op_sign  in  1  1 = signed overflow rule, 0 = unsigned.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- result  out  2*HALF_W  sum/difference.
- ofl  out  1  overflow/borrow flag.
- zero  out  1  result == 0.
- add_a  out  HALF_W  to adder InA.
- add_b  out  HALF_W  to adder InB.
- add_cin  out  1  to adder Cin.
- add_sign  out  1  to adder sign.
- add_sum  in  HALF_W  from adder Out.
- add_ofl  in  1  from adder Ofl. This is the carry-out when add_sign=0 and the signed overflow when add_sign=1.

Behaviour:
- FSM states: IDLE, LO, HI, DONE. Reset (rst_n low, asynchronous) forces:
  - state=IDLE;
  - result=0, ofl=0, zero=0, resp_valid=0;
  - all internal operand, carry and flag registers cleared.
- IDLE:
  - req_ready=1.
  - On req_valid at a clk edge, capture:
    - a_q=op_a;
    - b_q = op_sub ? ~op_b : op_b;
    - cin_q=op_sub;
    - sub_q=op_sub;
    - sign_q=op_sign.
  - Go to LO. Without req_valid, stay in IDLE.
- LO:
  - Drive add_a=a_q[HALF_W-1:0], add_b=b_q[HALF_W-1:0], add_cin=cin_q, add_sign=0.
  - At the edge: result[HALF_W-1:0] <= add_sum; carry_q <= add_ofl.
  - Go to HI.
- HI:
  - Drive the upper halves, add_cin=carry_q, add_sign=sign_q.
  - At the edge: result[2*HALF_W-1:HALF_W] <= add_sum.
  - ofl is set as follows:
    - add_ofl when sign_q=1;
    - add_ofl when sign_q=0 and sub_q=0;
    - ~add_ofl when sign_q=0 and sub_q=1 (borrow).
  - zero <= (upper add_sum==0) & (low result==0).
  - Go to DONE.
- DONE:
  - resp_valid=1.
  - result, ofl and zero held stable.
  - On resp_ready go to IDLE; resp_valid drops the next cycle.
- Adder drive outside LO/HI: add_a=0, add_b=0, add_cin=0, add_sign=0. The adder is purely combinational, so one pass per cycle is sufficient.
- Latency: request accepted at edge N; resp_valid high from N+2 (after the HI edge). Throughput is one op per 3 cycles minimum (accept, LO, HI), plus DONE/handshake.
- req_valid outside IDLE is ignored (req_ready=0). Op operands may change after acceptance without effect.
- result/ofl/zero keep the last completed values in IDLE until the next HI edge overwrites them. The low half of result updates at LO of the next op; consumers must only sample while resp_valid=1.
- Reset mid-operation (any state): immediate return to IDLE with cleared outputs; the in-flight op is discarded and no response is produced.
- No wrap or width growth: result is the modulo-2^(2*HALF_W) sum. Overflow is reported only via ofl.

Test Plan:
- 0x0000FFFF + 0x00000001, unsigned, resp_ready=1 -> result=0x00010000, ofl=0, zero=0; resp_valid 2 edges after acceptance, req_ready low during LO/HI/DONE.
- 0xFFFFFFFF + 0x00000001, unsigned -> result=0x00000000, ofl=1, zero=1; add_cin=1 observed during HI.
- 0x80000000 - 0x00000001, signed -> result=0x7FFFFFFF, ofl=1; 0x00000005 - 0x00000003, signed -> 0x00000002, ofl=0.
- 0x00000003 - 0x00000005, unsigned -> result=0xFFFFFFFE, ofl=1 (borrow); 5-3 unsigned -> 0x00000002, ofl=0.
- Backpressure: resp_ready=0 for 4 cycles after resp_valid with req_valid held high and a new operand -> result/ofl/zero constant, req_ready=0, second op accepted only on the cycle after the DONE->IDLE handshake.
- rst_n pulsed low during HI of 0x12345678+0x11111111 -> outputs 0 asynchronously, state IDLE, no resp_valid; the next op 1+1 completes with result=0x00000002.
